// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: opcodes, decoder alu_op codes, funct3/funct7,
// instruction format enum, canonical NOP, and the encoder FSM state type.
// Imported by the encoder, its packer, and the matching decoder.
package riscv_pkg;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  // alu_op codes as produced by the decoder: 0-9 R-type, 10-18 I-type
  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_XOR   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_AND   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_ADDI  = 5'd10;
  localparam logic [4:0] ALU_XORI  = 5'd11;
  localparam logic [4:0] ALU_ORI   = 5'd12;
  localparam logic [4:0] ALU_ANDI  = 5'd13;
  localparam logic [4:0] ALU_SLLI  = 5'd14;
  localparam logic [4:0] ALU_SRLI  = 5'd15;
  localparam logic [4:0] ALU_SRAI  = 5'd16;
  localparam logic [4:0] ALU_SLTI  = 5'd17;
  localparam logic [4:0] ALU_SLTIU = 5'd18;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {FMT_R = 2'd0, FMT_I = 2'd1, FMT_B = 2'd2, FMT_ILL = 2'd3} fmt_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FULL = 2'd2} state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-set input channel (valid/ready) and instruction-memory write port.
// slave: the encoder side; master: the program source / memory model side.
// Latency and backpressure are defined by the encoder using this bundle.
interface instr_encoder_if #(parameter int REG_AW = 5);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [1:0]        in_fmt;
  logic [4:0]        in_alu_op;
  logic [2:0]        in_b_type;
  logic [REG_AW-1:0] in_rd;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport slave (
    input  in_valid, in_last, in_fmt, in_alu_op, in_b_type, in_rd, in_rs1, in_rs2, in_imm,
    input  mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_last, in_fmt, in_alu_op, in_b_type, in_rd, in_rs1, in_rs2, in_imm,
    output mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational fields-to-RV32I-word packer with illegal/range flags.
// Ports: fmt/alu_op/b_type/rd/rs1/rs2/imm in; word_o, illegal_o, range_o out.
// Zero latency, no handshake. Range checks only under ENCODER_RANGE_CHECK_EN.
module instr_pack
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [1:0]        fmt_i,
  input  logic [4:0]        alu_op_i,
  input  logic [2:0]        b_type_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [31:0]       imm_i,
  output logic [31:0]       word_o,
  output logic              illegal_o,
  output logic              range_o
);

  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm12;
  logic        bad;

  // Register fields are always 5 bits in the word
  if (REG_AW >= 5) begin : g_trunc
    assign rd  = rd_i[4:0];
    assign rs1 = rs1_i[4:0];
    assign rs2 = rs2_i[4:0];
  end else begin : g_ext
    assign rd  = {{(5-REG_AW){1'b0}}, rd_i};
    assign rs1 = {{(5-REG_AW){1'b0}}, rs1_i};
    assign rs2 = {{(5-REG_AW){1'b0}}, rs2_i};
  end

  always_comb begin
    word_o = NOP;
    bad    = 1'b0;
    f3     = F3_ADD;
    f7     = F7_BASE;
    imm12  = imm_i[11:0];
    case (fmt_i)
      FMT_R: begin
        case (alu_op_i)
          ALU_ADD:  f3 = F3_ADD;
          ALU_SUB:  begin f3 = F3_ADD; f7 = F7_ALT; end
          ALU_XOR:  f3 = F3_XOR;
          ALU_OR:   f3 = F3_OR;
          ALU_AND:  f3 = F3_AND;
          ALU_SLL:  f3 = F3_SLL;
          ALU_SRL:  f3 = F3_SR;
          ALU_SRA:  begin f3 = F3_SR; f7 = F7_ALT; end
          ALU_SLT:  f3 = F3_SLT;
          ALU_SLTU: f3 = F3_SLTU;
          default:  bad = 1'b1;
        endcase
        if (!bad) word_o = {f7, rs2, rs1, f3, rd, OPC_R};
      end
      FMT_I: begin
        case (alu_op_i)
          ALU_ADDI:  f3 = F3_ADD;
          ALU_XORI:  f3 = F3_XOR;
          ALU_ORI:   f3 = F3_OR;
          ALU_ANDI:  f3 = F3_AND;
          ALU_SLLI:  begin f3 = F3_SLL; imm12 = {F7_BASE, imm_i[4:0]}; end
          ALU_SRLI:  begin f3 = F3_SR;  imm12 = {F7_BASE, imm_i[4:0]}; end
          ALU_SRAI:  begin f3 = F3_SR;  imm12 = {F7_ALT, imm_i[4:0]}; end
          ALU_SLTI:  f3 = F3_SLT;
          ALU_SLTIU: f3 = F3_SLTU;
          default:   bad = 1'b1;
        endcase
        if (!bad) word_o = {imm12, rs1, f3, rd, OPC_I};
      end
      FMT_B: begin
        // imm[0] has no slot in the B layout
        word_o = {imm_i[12], imm_i[10:5], rs2, rs1, b_type_i, imm_i[4:1], imm_i[11], OPC_B};
      end
      default: bad = 1'b1;
    endcase
    illegal_o = bad;
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic is_shift;
  assign is_shift = (alu_op_i == ALU_SLLI) || (alu_op_i == ALU_SRLI) || (alu_op_i == ALU_SRAI);

  always_comb begin
    range_o = 1'b0;
    if (!bad) begin
      case (fmt_i)
        FMT_I: begin
          if (is_shift) range_o = (imm_i > 32'd31);
          else          range_o = ($signed(imm_i) < -32'sd2048) || ($signed(imm_i) > 32'sd2047);
        end
        FMT_B: range_o = imm_i[0] || ($signed(imm_i) < -32'sd4096) || ($signed(imm_i) > 32'sd4094);
        default: range_o = 1'b0;
      endcase
    end
  end
`else
  assign range_o = 1'b0;
`endif

  // Upper immediate bits only matter to the range check
  logic unused_imm;
  assign unused_imm = ^imm_i[31:13];

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs decoded field sets into RV32I words, writes them sequentially.
// Ports: clk, rst (sync, active-high), start, bus (fields in / mem write out), full, done, err.
// 1-cycle accept-to-write latency; write held until mem_ready; 1 word/cycle when ready.
// Optional macro ENCODER_RANGE_CHECK_EN adds immediate range errors (see instr_pack).
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int          REG_AW    = 5,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  instr_encoder_if.slave   bus,
  output logic             full,
  output logic             done,
  output logic             err
);

  localparam int            SW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          we_q, we_d;
  logic          last_q, last_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          full_q, full_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [31:0] pk_word;
  logic        pk_illegal, pk_range;
  logic        wr_done, accept, in_ready;

  instr_pack #(.REG_AW(REG_AW)) u_pack (
    .fmt_i     (bus.in_fmt),
    .alu_op_i  (bus.in_alu_op),
    .b_type_i  (bus.in_b_type),
    .rd_i      (bus.in_rd),
    .rs1_i     (bus.in_rs1),
    .rs2_i     (bus.in_rs2),
    .imm_i     (bus.in_imm),
    .word_o    (pk_word),
    .illegal_o (pk_illegal),
    .range_o   (pk_range)
  );

  assign wr_done = we_q && bus.mem_ready;

  // Beyond the basic slot-free rule, refuse a new field set while the pending
  // word fills the last slot (no wrap) or ends the program (nothing may follow it).
  assign in_ready = !rst && (state_q == ST_RUN) && !start &&
                    (!we_q || (bus.mem_ready && (slot_q != LAST_SLOT) && !last_q));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    we_d    = we_q;
    last_d  = last_q;
    wdata_d = wdata_q;
    full_d  = full_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (start) begin
      // Restart drops any pending write
      state_d = ST_RUN;
      slot_d  = '0;
      we_d    = 1'b0;
      last_d  = 1'b0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (wr_done) begin
        we_d = 1'b0;
        if (last_q) done_d = 1'b1;
        if (slot_q == LAST_SLOT) begin
          full_d  = 1'b1;
          state_d = ST_FULL;
        end else begin
          slot_d = slot_q + SW'(1);
          if (last_q) state_d = ST_IDLE;
        end
      end
      if (accept) begin
        we_d    = 1'b1;
        wdata_d = pk_word;
        last_d  = bus.in_last;
        err_d   = err_q | pk_illegal | pk_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      wdata_q <= 32'h0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      we_q    <= we_d;
      last_q  <= last_d;
      wdata_q <= wdata_d;
      full_q  <= full_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_addr  = BASE_ADDR + {{(30-SW){1'b0}}, slot_q, 2'b00};
  assign full          = full_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst, start, full, done, err;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.REG_AW(5)) bus ();

  instr_encoder #(.REG_AW(5), .DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .full  (full),
    .done  (done),
    .err   (err)
  );

`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  op;
    logic [2:0]  bt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] f, input logic [4:0] op, input logic [2:0] bt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic last);
    bus.in_fmt    = f;
    bus.in_alu_op = op;
    bus.in_b_type = bt;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int acc, wr;
    vecs[0]  = '{2'd0, 5'd0,  3'd0, 5'd3,  5'd1,  5'd2,  32'h0,        32'h002081B3, 1'b0};
    vecs[1]  = '{2'd0, 5'd1,  3'd0, 5'd1,  5'd2,  5'd3,  32'h5A5A,     32'h403100B3, 1'b0};
    vecs[2]  = '{2'd0, 5'd2,  3'd0, 5'd5,  5'd6,  5'd7,  32'h0,        32'h007342B3, 1'b0};
    vecs[3]  = '{2'd0, 5'd7,  3'd0, 5'd10, 5'd11, 5'd12, 32'h0,        32'h40C5D533, 1'b0};
    vecs[4]  = '{2'd0, 5'd9,  3'd0, 5'd31, 5'd31, 5'd31, 32'h0,        32'h01FFBFB3, 1'b0};
    vecs[5]  = '{2'd1, 5'd10, 3'd0, 5'd5,  5'd0,  5'd9,  32'hFFFFFFFF, 32'hFFF00293, 1'b0};
    vecs[6]  = '{2'd1, 5'd16, 3'd0, 5'd4,  5'd4,  5'd0,  32'h3,        32'h40325213, 1'b0};
    vecs[7]  = '{2'd1, 5'd13, 3'd0, 5'd1,  5'd2,  5'd0,  32'h7FF,      32'h7FF17093, 1'b0};
    vecs[8]  = '{2'd1, 5'd17, 3'd0, 5'd2,  5'd3,  5'd0,  32'hFFFFF800, 32'h8001A113, 1'b0};
    vecs[9]  = '{2'd1, 5'd14, 3'd0, 5'd1,  5'd1,  5'd0,  32'd31,       32'h01F09093, 1'b0};
    vecs[10] = '{2'd2, 5'd0,  3'd0, 5'd7,  5'd1,  5'd2,  32'd8,        32'h00208463, 1'b0};
    vecs[11] = '{2'd2, 5'd0,  3'd1, 5'd0,  5'd5,  5'd6,  32'hFFFFFFFC, 32'hFE629EE3, 1'b0};
    vecs[12] = '{2'd2, 5'd0,  3'd7, 5'd0,  5'd0,  5'd0,  32'd4094,     32'h7E007FE3, 1'b0};
    vecs[13] = '{2'd0, 5'd12, 3'd0, 5'd1,  5'd2,  5'd3,  32'h0,        32'h00000013, 1'b1};
    vecs[14] = '{2'd3, 5'd0,  3'd0, 5'd1,  5'd2,  5'd3,  32'h0,        32'h00000013, 1'b1};
    vecs[15] = '{2'd1, 5'd5,  3'd0, 5'd1,  5'd2,  5'd0,  32'h1,        32'h00000013, 1'b1};
    vecs[16] = '{2'd1, 5'd10, 3'd0, 5'd1,  5'd0,  5'd0,  32'd2048,     32'h80000093, RC};
    vecs[17] = '{2'd1, 5'd14, 3'd0, 5'd1,  5'd1,  5'd0,  32'd32,       32'h00009093, RC};
    vecs[18] = '{2'd2, 5'd0,  3'd0, 5'd0,  5'd0,  5'd0,  32'd3,        32'h00000163, RC};

    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_fmt = 2'd0; bus.in_alu_op = 5'd0;
    bus.in_b_type = 3'd0; bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
    bus.in_imm = 32'h0; bus.mem_ready = 1'b1;

    // Reset state
    tick();
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_mem_we",    {31'b0, bus.mem_we}, 32'd0);
    check("rst_mem_addr",  bus.mem_addr,        32'h0);
    check("rst_mem_wdata", bus.mem_wdata,       32'h0);
    check("rst_flags",     {29'b0, full, done, err}, 32'd0);
    check("idle_in_ready", {31'b0, bus.in_ready}, 32'd0);

    // Encoding table: one word per restart, always at BASE_ADDR
    for (int i = 0; i < 19; i++) begin
      pulse_start();
      drive(vecs[i].fmt, vecs[i].op, vecs[i].bt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].imm, 1'b0);
      #1;
      check($sformatf("vec%0d_in_ready", i), {31'b0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_we", i),    {31'b0, bus.mem_we}, 32'd1);
      check($sformatf("vec%0d_addr", i),  bus.mem_addr,        32'h0);
      check($sformatf("vec%0d_word", i),  bus.mem_wdata,       vecs[i].word);
      check($sformatf("vec%0d_err", i),   {31'b0, err},        {31'b0, vecs[i].err});
      tick();
    end

    // Back-to-back ADDI / SRAI
    pulse_start();
    bus.mem_ready = 1'b1;
    drive(2'd1, 5'd10, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    #1;
    tick();
    drive(2'd1, 5'd16, 3'd0, 5'd4, 5'd4, 5'd0, 32'h3, 1'b0);
    #1;
    check("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("b2b_w0",       bus.mem_wdata, 32'hFFF00293);
    check("b2b_a0",       bus.mem_addr,  32'h0);
    tick();
    bus.in_valid = 1'b0;
    check("b2b_we1", {31'b0, bus.mem_we}, 32'd1);
    check("b2b_w1",  bus.mem_wdata, 32'h40325213);
    check("b2b_a1",  bus.mem_addr,  32'h4);
    tick();
    check("b2b_we_off", {31'b0, bus.mem_we}, 32'd0);

    // Branch with in_last, stalled three cycles
    pulse_start();
    bus.mem_ready = 1'b0;
    drive(2'd2, 5'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
    #1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall%0d_we", c),    {31'b0, bus.mem_we},   32'd1);
      check($sformatf("stall%0d_word", c),  bus.mem_wdata,         32'h00208463);
      check($sformatf("stall%0d_addr", c),  bus.mem_addr,          32'h0);
      check($sformatf("stall%0d_rdy", c),   {31'b0, bus.in_ready}, 32'd0);
      check($sformatf("stall%0d_done", c),  {31'b0, done},         32'd0);
      tick();
    end
    bus.mem_ready = 1'b1;
    tick();
    check("last_done",     {31'b0, done},       32'd1);
    check("last_we_off",   {31'b0, bus.mem_we}, 32'd0);
    tick();
    check("last_done_off", {31'b0, done},       32'd0);
    check("last_idle_rdy", {31'b0, bus.in_ready}, 32'd0);

    // Fill all DEPTH=4 slots; a fifth word must not be taken
    pulse_start();
    bus.mem_ready = 1'b1;
    drive(2'd0, 5'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
    #1;
    acc = 0; wr = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.in_ready) acc++;
      if (bus.mem_we && bus.mem_ready) begin
        check($sformatf("fill_addr%0d", wr), bus.mem_addr, 32'(4 * wr));
        wr++;
      end
      tick();
    end
    check("fill_accepts", 32'(acc), 32'd4);
    check("fill_writes",  32'(wr),  32'd4);
    check("fill_full",    {31'b0, full}, 32'd1);
    check("fill_rdy",     {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    pulse_start();
    check("refill_full", {31'b0, full}, 32'd0);
    check("refill_addr", bus.mem_addr, 32'h0);
    drive(2'd0, 5'd2, 3'd0, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0);
    #1;
    tick();
    bus.in_valid = 1'b0;
    check("refill_we",   {31'b0, bus.mem_we}, 32'd1);
    check("refill_a0",   bus.mem_addr,  32'h0);
    check("refill_word", bus.mem_wdata, 32'h007342B3);
    tick();

    // Illegal op: NOP written, err sticky until start
    pulse_start();
    drive(2'd0, 5'd12, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
    #1;
    tick();
    bus.in_valid = 1'b0;
    check("ill_word", bus.mem_wdata, 32'h00000013);
    check("ill_err",  {31'b0, err}, 32'd1);
    tick();
    tick();
    check("ill_err_hold", {31'b0, err}, 32'd1);
    drive(2'd0, 5'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
    #1;
    tick();
    bus.in_valid = 1'b0;
    check("ill_err_after_ok", {31'b0, err}, 32'd1);
    check("ill_next_word",    bus.mem_wdata, 32'h002081B3);
    check("ill_next_addr",    bus.mem_addr,  32'h4);
    tick();
    pulse_start();
    check("ill_err_clear", {31'b0, err}, 32'd0);

    // start while a write is pending drops it
    bus.mem_ready = 1'b1;
    drive(2'd0, 5'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
    #1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.mem_ready = 1'b0;
    drive(2'd0, 5'd1, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
    #1;
    tick();
    bus.in_valid = 1'b0;
    check("drop_pend_we",   {31'b0, bus.mem_we}, 32'd1);
    check("drop_pend_addr", bus.mem_addr, 32'h4);
    pulse_start();
    check("drop_we",   {31'b0, bus.mem_we}, 32'd0);
    check("drop_addr", bus.mem_addr, 32'h0);
    bus.mem_ready = 1'b1;
    drive(2'd0, 5'd2, 3'd0, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0);
    #1;
    tick();
    bus.in_valid = 1'b0;
    check("drop_new_we",   {31'b0, bus.mem_we}, 32'd1);
    check("drop_new_addr", bus.mem_addr, 32'h0);
    check("drop_new_word", bus.mem_wdata, 32'h007342B3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
